// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch sequencer's bus-side and pipeline-side signals.
// master: the fetch_ctrl view; slave: the instruction bus / pipeline view.
interface fetch_ctrl_if;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        id_ready_i;
  logic        busy_o;

  modport master (
    input  redirect_i, redirect_addr_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, id_ready_i,
    output ibus_req_o, ibus_addr_o, inst_valid_o, inst_o, inst_pc_o, busy_o
  );

  modport slave (
    output redirect_i, redirect_addr_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, id_ready_i,
    input  ibus_req_o, ibus_addr_o, inst_valid_o, inst_o, inst_pc_o, busy_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues word fetches on a req/gnt/rvalid bus,
// buffers returned words with their PCs and hands them to IF/ID in order.
module fetch_ctrl #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] END_ADDR   = 32'h0000_3FFC,
  parameter int          DEPTH      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_reg;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] out_cnt_reg, out_cnt_next;
  logic [CW-1:0] disc_cnt_reg, disc_cnt_next;
  logic [CW-1:0] q_cnt_reg, q_cnt_next;
  logic [AW-1:0] q_wr_ptr_reg, q_wr_ptr_next;
  logic [AW-1:0] q_rd_ptr_reg, q_rd_ptr_next;
  logic [AW-1:0] pcf_wr_ptr_reg, pcf_rd_ptr_reg;

  logic [31:0] q_inst_reg [DEPTH];
  logic [31:0] q_pc_reg   [DEPTH];
  logic [31:0] pcf_reg    [DEPTH];

  logic          inst_valid;
  logic          q_pop;
  logic          q_push;
  logic          rsp_drop;
  logic          grant;
  logic          req;
  logic [CW:0]   occupancy;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.redirect_addr_i[1:0];

  assign inst_valid = (q_cnt_reg != '0) && !bus.redirect_i;
  assign q_pop      = inst_valid && bus.id_ready_i;

  // A word leaving the queue this cycle frees its slot for a new request,
  // which is what lets DEPTH=2 sustain one fetch per cycle.
  assign occupancy  = {1'b0, out_cnt_reg} + {1'b0, q_cnt_reg} - {{CW{1'b0}}, q_pop};
  assign req        = (state_reg == S_RUN) && (occupancy < (CW+1)'(DEPTH));
  assign grant      = req && bus.ibus_gnt_i;

  assign rsp_drop   = bus.ibus_rvalid_i && ((disc_cnt_reg != '0) || bus.redirect_i);
  assign q_push     = bus.ibus_rvalid_i && !rsp_drop;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (bus.redirect_i)
      fetch_pc_next = {bus.redirect_addr_i[31:2], 2'b00};
    else if (grant)
      fetch_pc_next = (fetch_pc_reg >= END_ADDR) ? START_ADDR : fetch_pc_reg + 32'd4;
  end

  always_comb begin
    out_cnt_next  = out_cnt_reg + CW'(grant) - CW'(bus.ibus_rvalid_i);
    disc_cnt_next = disc_cnt_reg;
    // Everything still in flight after a redirect belongs to the old stream.
    if (bus.redirect_i)
      disc_cnt_next = out_cnt_next;
    else if (bus.ibus_rvalid_i && (disc_cnt_reg != '0))
      disc_cnt_next = disc_cnt_reg - CW'(1);
  end

  always_comb begin
    q_cnt_next    = q_cnt_reg + CW'(q_push) - CW'(q_pop);
    q_wr_ptr_next = q_wr_ptr_reg + AW'(q_push);
    q_rd_ptr_next = q_rd_ptr_reg + AW'(q_pop);
    if (bus.redirect_i) begin
      q_cnt_next    = '0;
      q_wr_ptr_next = '0;
      q_rd_ptr_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= START_ADDR;
      out_cnt_reg    <= '0;
      disc_cnt_reg   <= '0;
      q_cnt_reg      <= '0;
      q_wr_ptr_reg   <= '0;
      q_rd_ptr_reg   <= '0;
      pcf_wr_ptr_reg <= '0;
      pcf_rd_ptr_reg <= '0;
    end else begin
      state_reg      <= S_RUN;
      fetch_pc_reg   <= fetch_pc_next;
      out_cnt_reg    <= out_cnt_next;
      disc_cnt_reg   <= disc_cnt_next;
      q_cnt_reg      <= q_cnt_next;
      q_wr_ptr_reg   <= q_wr_ptr_next;
      q_rd_ptr_reg   <= q_rd_ptr_next;
      pcf_wr_ptr_reg <= pcf_wr_ptr_reg + AW'(grant);
      pcf_rd_ptr_reg <= pcf_rd_ptr_reg + AW'(bus.ibus_rvalid_i);
    end
  end

  // The PC record is never flushed: stale responses still retire their entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pcf_reg[gi] <= '0;
        end else if (grant && (pcf_wr_ptr_reg == AW'(gi))) begin
          pcf_reg[gi] <= fetch_pc_reg;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_inst_reg[gi] <= '0;
          q_pc_reg[gi]   <= '0;
        end else if (q_push && (q_wr_ptr_reg == AW'(gi))) begin
          q_inst_reg[gi] <= bus.ibus_rdata_i;
          q_pc_reg[gi]   <= pcf_reg[pcf_rd_ptr_reg];
        end
      end
    end
  endgenerate

  assign bus.ibus_req_o   = req;
  assign bus.ibus_addr_o  = fetch_pc_reg;
  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_o       = q_inst_reg[q_rd_ptr_reg];
  assign bus.inst_pc_o    = q_pc_reg[q_rd_ptr_reg];
  assign bus.busy_o       = (out_cnt_reg != '0) || (disc_cnt_reg != '0);

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    bus.ibus_rvalid_i |-> (out_cnt_reg != '0));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, out_cnt_reg} + {1'b0, q_cnt_reg}) <= (CW+1)'(DEPTH));
  a_discard_bound: assert property (@(posedge clk) disable iff (!rst_n)
    disc_cnt_reg <= out_cnt_reg);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised bench for fetch_ctrl: an in-bench transaction model (queues of
// in-flight requests and buffered words) predicts every output each cycle.
module tb_fetch_ctrl;

  localparam logic [31:0] START_ADDR = 32'h0000_0000;
  localparam logic [31:0] END_ADDR   = 32'h0000_3FFC;
  localparam int          DEPTH      = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus_if ();

  fetch_ctrl #(
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  req_t        inflight[$];
  ent_t        buffered[$];
  logic [31:0] m_pc;
  bit          m_run;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_grants;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    buffered.delete();
    m_pc  = START_ADDR;
    m_run = 1'b0;
  endtask

  task automatic drive(input bit gnt, input bit rv, input bit rdy,
                       input bit redir, input logic [31:0] raddr);
    bit do_rv;
    do_rv = rv && rst_n && (inflight.size() > 0);
    bus_if.ibus_gnt_i      = gnt;
    bus_if.ibus_rvalid_i   = do_rv;
    bus_if.ibus_rdata_i    = do_rv ? word_of(inflight[0].addr) : $urandom;
    bus_if.id_ready_i      = rdy;
    bus_if.redirect_i      = redir;
    bus_if.redirect_addr_i = raddr;
  endtask

  task automatic chk_reset_values();
    chk("rst_req",   {31'b0, bus_if.ibus_req_o},   32'h0);
    chk("rst_addr",  bus_if.ibus_addr_o,           START_ADDR);
    chk("rst_valid", {31'b0, bus_if.inst_valid_o}, 32'h0);
    chk("rst_inst",  bus_if.inst_o,                32'h0);
    chk("rst_pc",    bus_if.inst_pc_o,             32'h0);
    chk("rst_busy",  {31'b0, bus_if.busy_o},       32'h0);
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic cyc();
    bit   exp_valid, exp_req, pop, grant, redir;
    int   occ;
    req_t r;
    @(negedge clk);
    if (!rst_n) begin
      chk_reset_values();
      model_reset();
    end else begin
      redir     = bus_if.redirect_i;
      exp_valid = (buffered.size() > 0) && !redir;
      pop       = exp_valid && bus_if.id_ready_i;
      occ       = inflight.size() + buffered.size() - (pop ? 1 : 0);
      exp_req   = m_run && (occ < DEPTH);
      grant     = exp_req && bus_if.ibus_gnt_i;

      chk("req",   {31'b0, bus_if.ibus_req_o},   {31'b0, exp_req});
      chk("addr",  bus_if.ibus_addr_o,           m_pc);
      chk("valid", {31'b0, bus_if.inst_valid_o}, {31'b0, exp_valid});
      chk("busy",  {31'b0, bus_if.busy_o},       {31'b0, inflight.size() != 0});
      if (exp_valid) begin
        chk("inst",    bus_if.inst_o,    buffered[0].inst);
        chk("inst_pc", bus_if.inst_pc_o, buffered[0].pc);
      end

      if (pop) begin
        $display("deliver pc=%h inst=%h t=%0t", buffered[0].pc, buffered[0].inst, $time);
        void'(buffered.pop_front());
      end
      if (bus_if.ibus_rvalid_i) begin
        r = inflight.pop_front();
        if (!r.stale && !redir)
          buffered.push_back('{inst: bus_if.ibus_rdata_i, pc: r.addr});
      end
      if (grant) begin
        inflight.push_back('{addr: m_pc, stale: redir});
        m_pc = (m_pc >= END_ADDR) ? START_ADDR : m_pc + 32'd4;
      end
      if (redir) begin
        buffered.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc = {bus_if.redirect_addr_i[31:2], 2'b00};
      end
      m_run = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    drive(0, 0, 1, 0, 32'h0);
    for (int i = 0; i < n; i++) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive(0, 0, 1, 0, 32'h0);
    @(posedge clk);
    #1;
    reset_cycles(2);

    // Streaming with redirects to 0x102 and near the wrap point.
    for (int k = 0; k < 22; k++) begin
      if (k == 8)
        drive(1, 1, 1, 1, 32'h0000_0102);
      else if (k == 14)
        drive(1, 1, 1, 1, 32'h0000_3FFB);
      else
        drive(1, 1, 1, 0, 32'h0);
      #1;
      if (k == 0)  chk("lit_idle_req",  {31'b0, bus_if.ibus_req_o}, 32'h0);
      if (k == 1)  chk("lit_first_req", {bus_if.ibus_addr_o[31:1], bus_if.ibus_req_o}, 32'h1);
      if (k == 5)  chk("lit_stream_addr", bus_if.ibus_addr_o, 32'h10);
      if (k == 5)  chk("lit_stream_pc",   bus_if.inst_pc_o,   32'h8);
      if (k == 9)  chk("lit_redir_addr",  bus_if.ibus_addr_o, 32'h100);
      if (k == 11) chk("lit_redir_pc",    bus_if.inst_pc_o,   32'h100);
      if (k == 16) chk("lit_end_addr",    bus_if.ibus_addr_o, 32'h3FFC);
      if (k == 17) chk("lit_wrap_addr",   bus_if.ibus_addr_o, 32'h0);
      if (k == 18) chk("lit_end_pc",      bus_if.inst_pc_o,   32'h3FFC);
      if (k == 19) chk("lit_wrap_pc",     bus_if.inst_pc_o,   32'h0);
      cyc();
    end

    // Stall from reset: only DEPTH requests may issue.
    reset_cycles(2);
    stall_grants = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 0, 0, 32'h0);
      #1;
      if (bus_if.ibus_req_o) stall_grants++;
      cyc();
    end
    chk("lit_stall_grants", stall_grants, DEPTH);
    chk("lit_stall_pc",     bus_if.inst_pc_o, 32'h0);
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 1, 0, 32'h0);
      cyc();
    end

    // Grant withheld, then an asynchronous reset mid-wait.
    drive(1, 0, 0, 0, 32'h0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 32'h0);
      cyc();
    end
    rst_n = 1'b0;
    drive(0, 0, 1, 0, 32'h0);
    #1;
    chk_reset_values();
    cyc();
    cyc();
    rst_n = 1'b1;

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] ra;
      ra = ($urandom % 4 == 0) ? (32'h0000_3FF0 + ($urandom % 16))
                               : {18'b0, 14'($urandom)} + (($urandom % 8 == 0) ? 32'h0000_4000 : 32'h0);
      drive($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 4 != 0,
            $urandom % 14 == 0, ra);
      if ($urandom % 500 == 0) begin
        rst_n = 1'b0;
        drive(0, 0, 1, 0, 32'h0);
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
